// File: rtl/fifo_word_reader.sv
// Reads bytes from an upstream 8-bit FIFO and packs them little-endian into 32-bit words,
// with flush of partial words, downstream backpressure, a transfer counter and a sticky error flag.
module fifo_word_reader (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_data_valid,
  input  logic        flush,
  output logic [31:0] word_out,
  output logic [2:0]  word_bytes,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [15:0] words_sent,
  output logic        err
);

  logic [31:0] asm_q, asm_d;
  logic [2:0]  lane_q, lane_d;
  logic        pend_q, pend_d;
  logic        flush_q, flush_d;
  logic [31:0] out_q, out_d;
  logic [2:0]  out_bytes_q, out_bytes_d;
  logic        out_vld_q, out_vld_d;
  logic [15:0] sent_q, sent_d;
  logic        err_q, err_d;

  logic        accept, out_free, take, pend_left, flush_req, flush_ok, move;
  logic [31:0] asm_a;
  logic [2:0]  lane_a;

  always_comb begin
    accept    = out_vld_q & word_ready;
    out_free  = ~out_vld_q | word_ready;
    take      = fifo_data_valid & pend_q;
    pend_left = pend_q & ~fifo_data_valid;

    asm_a  = asm_q;
    lane_a = lane_q;
    if (take) begin
      asm_a[{lane_q[1:0], 3'b000} +: 8] = fifo_data;
      lane_a = lane_q + 3'd1;
    end

    // A flush can only be served once no read is still in flight.
    flush_req = flush_q | flush;
    flush_ok  = flush_req & ~pend_left;
    move      = out_free & ((lane_a == 3'd4) | (flush_ok & (lane_a != 3'd0)));

    // Cleared on every hand-off so unused upper bytes of a partial word read as zero.
    lane_d  = move ? 3'd0 : lane_a;
    asm_d   = move ? 32'd0 : asm_a;
    flush_d = flush_req & ~(flush_ok & (move | (lane_a == 3'd0)));

    // Free lanes are counted after this cycle's arrival and hand-off, which keeps reads back-to-back.
    fifo_rd = clear_n & ~fifo_empty & ~flush_req & ~pend_left & (lane_d < 3'd4);
    pend_d  = pend_left | fifo_rd;

    out_d       = out_q;
    out_bytes_d = out_bytes_q;
    out_vld_d   = out_vld_q & ~accept;
    if (move) begin
      out_d       = asm_a;
      out_bytes_d = lane_a;
      out_vld_d   = 1'b1;
    end

    sent_d = sent_q + {15'd0, accept};
    err_d  = err_q | (fifo_data_valid & ~pend_q);
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      asm_q       <= 32'd0;
      lane_q      <= 3'd0;
      pend_q      <= 1'b0;
      flush_q     <= 1'b0;
      out_q       <= 32'd0;
      out_bytes_q <= 3'd0;
      out_vld_q   <= 1'b0;
      sent_q      <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      lane_q      <= lane_d;
      pend_q      <= pend_d;
      flush_q     <= flush_d;
      out_q       <= out_d;
      out_bytes_q <= out_bytes_d;
      out_vld_q   <= out_vld_d;
      sent_q      <= sent_d;
      err_q       <= err_d;
    end
  end

  assign word_out   = out_q;
  assign word_bytes = out_bytes_q;
  assign word_valid = out_vld_q;
  assign words_sent = sent_q;
  assign err        = err_q;

endmodule

// File: tb/tb_fifo_word_reader.sv
// Bench for fifo_word_reader: a byte-FIFO model feeds the block, a monitor records transfers,
// and each scenario task compares what it saw against expectations built from the byte stream.
module tb_fifo_word_reader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear_n, fifo_empty, fifo_rd, fifo_data_valid, flush;
  logic        word_valid, word_ready, err;
  logic [7:0]  fifo_data;
  logic [31:0] word_out;
  logic [2:0]  word_bytes;
  logic [15:0] words_sent;

  int total = 0;
  int bad   = 0;

  // Upstream FIFO model: written by tasks, popped by the read strobe.
  logic [7:0] mem [0:1023];
  int         wp = 0;
  int         rp = 0;
  logic       fvld = 1'b0;
  logic [7:0] fdat = 8'h00;
  logic       force_vld = 1'b0;
  logic [7:0] force_dat = 8'h00;

  assign fifo_empty      = (rp == wp);
  assign fifo_data_valid = fvld | force_vld;
  assign fifo_data       = force_vld ? force_dat : fdat;

  always @(posedge clk) begin
    if (fifo_rd === 1'b1 && rp != wp) begin
      fdat <= mem[rp[9:0]];
      rp   <= rp + 1;
      fvld <= 1'b1;
    end else begin
      fvld <= 1'b0;
    end
  end

  fifo_word_reader dut (
    .clk             (clk),
    .clear_n         (clear_n),
    .fifo_empty      (fifo_empty),
    .fifo_rd         (fifo_rd),
    .fifo_data       (fifo_data),
    .fifo_data_valid (fifo_data_valid),
    .flush           (flush),
    .word_out        (word_out),
    .word_bytes      (word_bytes),
    .word_valid      (word_valid),
    .word_ready      (word_ready),
    .words_sent      (words_sent),
    .err             (err)
  );

  // Monitor: records transfers, read runs and protocol observations at the falling edge.
  logic [31:0] obs_w [$];
  logic [2:0]  obs_b [$];
  int          runs [$];
  int          rd_cnt = 0;
  int          run = 0;
  int          rd_empty = 0;
  int          stab_bad = 0;
  logic        hold = 1'b0;
  logic [31:0] hold_w = 32'd0;
  logic [2:0]  hold_b = 3'd0;

  always @(negedge clk) begin
    if (clear_n === 1'b1) begin
      if (hold && (word_valid !== 1'b1 || word_out !== hold_w || word_bytes !== hold_b))
        stab_bad <= stab_bad + 1;
      if (fifo_rd === 1'b1) begin
        rd_cnt <= rd_cnt + 1;
        run    <= run + 1;
        if (fifo_empty) rd_empty <= rd_empty + 1;
      end else begin
        if (run > 0) runs.push_back(run);
        run <= 0;
      end
      if (word_valid === 1'b1 && word_ready === 1'b1) begin
        obs_w.push_back(word_out);
        obs_b.push_back(word_bytes);
      end
      hold   <= (word_valid === 1'b1 && word_ready === 1'b0);
      hold_w <= word_out;
      hold_b <= word_bytes;
    end else begin
      hold <= 1'b0;
      run  <= 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp[9:0]] = b;
    wp = wp + 1;
  endtask

  task automatic do_reset();
    clear_n   = 1'b0;
    flush     = 1'b0;
    force_vld = 1'b0;
    cyc(1);
    clear_n = 1'b1;
  endtask

  task automatic test_reset();
    word_ready = 1'b1;
    flush      = 1'b0;
    force_vld  = 1'b0;
    clear_n    = 1'b0;
    cyc(2);
    total++; if (fifo_rd !== 1'b0) begin bad++; $display("FAIL reset_fifo_rd: got %b want 0", fifo_rd); end
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL reset_word_valid: got %b want 0", word_valid); end
    total++; if (word_out !== 32'd0) begin bad++; $display("FAIL reset_word_out: got %h want 0", word_out); end
    total++; if (word_bytes !== 3'd0) begin bad++; $display("FAIL reset_word_bytes: got %0d want 0", word_bytes); end
    total++; if (words_sent !== 16'd0) begin bad++; $display("FAIL reset_words_sent: got %0d want 0", words_sent); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    clear_n = 1'b1;
    cyc(2);
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid: got %b want 0", word_valid); end
  endtask

  task automatic test_stream();
    int w0, r0;
    logic [31:0] ew [2];
    ew[0] = 32'h04030201;
    ew[1] = 32'h08070605;
    do_reset();
    word_ready = 1'b1;
    w0 = obs_w.size();
    r0 = runs.size();
    for (int i = 1; i <= 8; i++) push(8'(i));
    cyc(16);
    total++; if (obs_w.size() - w0 != 2) begin bad++; $display("FAIL stream_count: got %0d want 2", obs_w.size() - w0); end
    for (int k = 0; k < 2 && w0 + k < obs_w.size(); k++) begin
      total++; if (obs_w[w0+k] !== ew[k]) begin bad++; $display("FAIL stream_word%0d: got %h want %h", k, obs_w[w0+k], ew[k]); end
      total++; if (obs_b[w0+k] !== 3'd4) begin bad++; $display("FAIL stream_bytes%0d: got %0d want 4", k, obs_b[w0+k]); end
    end
    total++; if (words_sent !== 16'd2) begin bad++; $display("FAIL stream_sent: got %0d want 2", words_sent); end
    total++;
    if (runs.size() - r0 != 1) begin bad++; $display("FAIL stream_rd_runs: got %0d runs want 1", runs.size() - r0); end
    else if (runs[r0] != 8) begin bad++; $display("FAIL stream_rd_run: got %0d want 8", runs[r0]); end
  endtask

  task automatic test_backpressure();
    int w0, rc0, s0;
    logic [31:0] ew [3];
    ew[0] = 32'h34333231;
    ew[1] = 32'h38373635;
    ew[2] = 32'h3C3B3A39;
    do_reset();
    word_ready = 1'b0;
    w0 = obs_w.size();
    s0 = stab_bad;
    cyc(1);
    rc0 = rd_cnt;
    for (int i = 0; i < 12; i++) push(8'(8'h31 + i));
    cyc(25);
    total++; if (rd_cnt - rc0 != 8) begin bad++; $display("FAIL bp_reads: got %0d want 8", rd_cnt - rc0); end
    total++; if (fifo_rd !== 1'b0) begin bad++; $display("FAIL bp_rd_low: got %b want 0", fifo_rd); end
    total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", word_valid); end
    total++; if (word_out !== ew[0]) begin bad++; $display("FAIL bp_held_word: got %h want %h", word_out, ew[0]); end
    total++; if (word_bytes !== 3'd4) begin bad++; $display("FAIL bp_held_bytes: got %0d want 4", word_bytes); end
    word_ready = 1'b1;
    cyc(25);
    total++; if (obs_w.size() - w0 != 3) begin bad++; $display("FAIL bp_count: got %0d want 3", obs_w.size() - w0); end
    for (int k = 0; k < 3 && w0 + k < obs_w.size(); k++) begin
      total++; if (obs_w[w0+k] !== ew[k]) begin bad++; $display("FAIL bp_word%0d: got %h want %h", k, obs_w[w0+k], ew[k]); end
    end
    total++; if (words_sent !== 16'd3) begin bad++; $display("FAIL bp_sent: got %0d want 3", words_sent); end
    total++; if (stab_bad - s0 != 0) begin bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stab_bad - s0); end
  endtask

  task automatic test_flush();
    int w0;
    do_reset();
    word_ready = 1'b1;
    w0 = obs_w.size();
    push(8'hAA); push(8'hBB); push(8'hCC);
    cyc(10);
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL flush_early_valid: got %b want 0", word_valid); end
    flush = 1'b1; cyc(1); flush = 1'b0;
    cyc(5);
    total++; if (obs_w.size() - w0 != 1) begin bad++; $display("FAIL flush_count: got %0d want 1", obs_w.size() - w0); end
    else begin
      total++; if (obs_w[w0] !== 32'h00CCBBAA) begin bad++; $display("FAIL flush_word: got %h want 00ccbbaa", obs_w[w0]); end
      total++; if (obs_b[w0] !== 3'd3) begin bad++; $display("FAIL flush_bytes: got %0d want 3", obs_b[w0]); end
    end
    flush = 1'b1; cyc(1); flush = 1'b0;
    cyc(5);
    total++; if (obs_w.size() - w0 != 1) begin bad++; $display("FAIL flush_empty_count: got %0d want 1", obs_w.size() - w0); end
    total++; if (words_sent !== 16'd1) begin bad++; $display("FAIL flush_sent: got %0d want 1", words_sent); end
    push(8'hDD); push(8'hEE); push(8'hFF); push(8'h01);
    cyc(10);
    total++; if (obs_w.size() - w0 != 2) begin bad++; $display("FAIL flush_resume_count: got %0d want 2", obs_w.size() - w0); end
    else begin
      total++; if (obs_w[w0+1] !== 32'h01FFEEDD) begin bad++; $display("FAIL flush_resume_word: got %h want 01ffeedd", obs_w[w0+1]); end
    end
  endtask

  task automatic test_empty();
    int rc0, w0;
    do_reset();
    word_ready = 1'b1;
    rc0 = rd_cnt;
    w0 = obs_w.size();
    cyc(20);
    total++; if (rd_cnt - rc0 != 0) begin bad++; $display("FAIL empty_reads: got %0d want 0", rd_cnt - rc0); end
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL empty_valid: got %b want 0", word_valid); end
    total++; if (obs_w.size() - w0 != 0) begin bad++; $display("FAIL empty_words: got %0d want 0", obs_w.size() - w0); end
  endtask

  task automatic test_reset_mid();
    int w0;
    do_reset();
    word_ready = 1'b1;
    push(8'hE1); push(8'hE2);
    cyc(6);
    w0 = obs_w.size();
    do_reset();
    for (int i = 0; i < 4; i++) push(8'(8'h11 + i));
    cyc(10);
    total++; if (obs_w.size() - w0 != 1) begin bad++; $display("FAIL midrst_count: got %0d want 1", obs_w.size() - w0); end
    else begin
      total++; if (obs_w[w0] !== 32'h14131211) begin bad++; $display("FAIL midrst_word: got %h want 14131211", obs_w[w0]); end
    end
    total++; if (words_sent !== 16'd1) begin bad++; $display("FAIL midrst_sent: got %0d want 1", words_sent); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL midrst_err: got %b want 0", err); end
  endtask

  task automatic test_spurious();
    int w0;
    do_reset();
    word_ready = 1'b1;
    w0 = obs_w.size();
    push(8'h21); push(8'h22);
    cyc(5);
    force_dat = 8'h99;
    force_vld = 1'b1;
    cyc(1);
    force_vld = 1'b0;
    cyc(1);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL spur_err: got %b want 1", err); end
    push(8'h23); push(8'h24);
    cyc(8);
    total++; if (obs_w.size() - w0 != 1) begin bad++; $display("FAIL spur_count: got %0d want 1", obs_w.size() - w0); end
    else begin
      total++; if (obs_w[w0] !== 32'h24232221) begin bad++; $display("FAIL spur_word: got %h want 24232221", obs_w[w0]); end
    end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL spur_sticky: got %b want 1", err); end
  endtask

  task automatic test_random();
    logic [7:0]  part [$];
    logic [31:0] exp_w [$];
    logic [2:0]  exp_b [$];
    logic [31:0] w;
    logic [7:0]  b;
    int w0, s0, n, guard;
    do_reset();
    w0 = obs_w.size();
    s0 = stab_bad;
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        push(b);
        part.push_back(b);
        if (part.size() == 4) begin
          w = {part[3], part[2], part[1], part[0]};
          exp_w.push_back(w);
          exp_b.push_back(3'd4);
          part.delete();
        end
        word_ready = 1'($urandom_range(0, 1));
        cyc($urandom_range(0, 2));
      end
      guard = 0;
      while (rp != wp && guard < 500) begin
        word_ready = 1'($urandom_range(0, 1));
        cyc(1);
        guard++;
      end
      total++; if (rp != wp) begin bad++; $display("FAIL rand_drain: got %0d bytes left want 0", wp - rp); end
      for (int i = 0; i < 3; i++) begin
        word_ready = 1'($urandom_range(0, 1));
        cyc(1);
      end
      if ($urandom_range(0, 2) == 0) begin
        if (part.size() > 0) begin
          w = 32'd0;
          for (int i = 0; i < part.size(); i++) w[8*i +: 8] = part[i];
          exp_w.push_back(w);
          exp_b.push_back(3'(part.size()));
          part.delete();
        end
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
      end
    end
    word_ready = 1'b1;
    cyc(20);
    total++; if (obs_w.size() - w0 != exp_w.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", obs_w.size() - w0, exp_w.size()); end
    for (int k = 0; k < exp_w.size() && w0 + k < obs_w.size(); k++) begin
      total++;
      if (obs_w[w0+k] !== exp_w[k] || obs_b[w0+k] !== exp_b[k]) begin
        bad++;
        $display("FAIL rand_word%0d: got %h/%0d want %h/%0d", k, obs_w[w0+k], obs_b[w0+k], exp_w[k], exp_b[k]);
      end
    end
    total++; if (words_sent !== 16'(exp_w.size())) begin bad++; $display("FAIL rand_sent: got %0d want %0d", words_sent, exp_w.size()); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rand_err: got %b want 0", err); end
    total++; if (stab_bad - s0 != 0) begin bad++; $display("FAIL rand_stable: got %0d unstable cycles want 0", stab_bad - s0); end
    total++; if (rd_empty != 0) begin bad++; $display("FAIL rd_while_empty: got %0d want 0", rd_empty); end
  endtask

  initial begin
    clear_n    = 1'b0;
    flush      = 1'b0;
    word_ready = 1'b0;
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_empty();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_word_reader.md
FIFO_WORD_READER -- requirements
Module: fifo_word_reader

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-low, named clear_n.
REQ-002 Parameter: none; all widths SHALL be fixed as listed below.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 clear_n  in  1  synchronous active-low reset.
REQ-005 fifo_empty  in  1  empty flag of the upstream 8-bit FIFO.
REQ-006 fifo_rd  out  1  read strobe to the FIFO; one byte is popped per cycle asserted.
REQ-007 fifo_data  in  8  FIFO read data; valid only when fifo_data_valid=1.
REQ-008 fifo_data_valid  in  1  FIFO read-data valid; asserted exactly one cycle after the fifo_rd that requested it.
REQ-009 flush  in  1  single-cycle request to emit a partially assembled word.
REQ-010 word_out  out  32  assembled word; the first byte read occupies bits [7:0] (little-endian).
REQ-011 word_bytes  out  3  number of valid bytes in word_out, 1..4.
REQ-012 word_valid  out  1  word_out/word_bytes valid.
REQ-013 word_ready  in  1  downstream accept; a transfer occurs on word_valid=1 and word_ready=1.
REQ-014 words_sent  out  16  count of completed transfers.
REQ-015 err  out  1  sticky protocol-error flag.

Function
REQ-016 The block SHALL hold an assembly register (4 bytes, lane count 0..4), an outstanding-read count pend (0..1), and a separate output register.
REQ-017 fifo_rd SHALL be asserted only when fifo_empty=0, no flush is pending, and lane+pend < 4; it SHALL never be asserted while fifo_empty=1.
REQ-018 Back-to-back reads SHALL be issued, sustaining one byte per cycle (one word per 4 cycles) when word_ready=1.
REQ-019 A byte arriving with fifo_data_valid=1 SHALL be written to lane position lane, and lane SHALL then increment.
REQ-020 When lane reaches 4 and the output register is empty or is being accepted in that cycle, the assembly SHALL move to the output register and lane SHALL reset to 0 in the same cycle.
REQ-021 word_valid SHALL rise in the cycle after the 4th byte's fifo_data_valid, with word_bytes=4.
REQ-022 If the output register is occupied and not accepted, a full assembly (lane=4) SHALL be held and no further fifo_rd SHALL be issued until the transfer occurs.
REQ-023 While word_valid=1 and word_ready=0, word_out, word_bytes and word_valid SHALL remain stable.
REQ-024 flush SHALL be latched as pending until served; while pending, new reads SHALL stop, and once pend=0 and lane>0 the partial word SHALL move to the output register, unused upper bytes set to 0 and word_bytes=lane.
REQ-025 If flush is pending and lane=0 with pend=0, the flush SHALL be cleared without emitting a word.
REQ-026 A flush coinciding with a 4th-byte arrival SHALL emit the full word (word_bytes=4) and then clear.
REQ-027 words_sent SHALL increment by 1 per transfer and wrap from 65535 to 0.
REQ-028 fifo_data_valid=1 with pend=0 SHALL set err=1 and the data byte SHALL be discarded; err clears only on reset.

Reset
REQ-029 On a rising clk edge with clear_n=0: fifo_rd=0, word_valid=0, word_out=0, word_bytes=0, words_sent=0, err=0, lane=0, pend=0, flush-pending=0.
REQ-030 A reset mid-word SHALL discard partially assembled bytes and any in-flight read; fifo_data_valid in the cycle after reset release SHALL be treated as spurious (REQ-028).

Verification
REQ-031 FIFO holds bytes 0x01..0x08, word_ready=1 -> word_out 0x04030201 then 0x08070605, word_bytes=4, words_sent=2, fifo_rd asserted 8 cycles back-to-back.
REQ-032 word_ready=0, FIFO holds 12 bytes -> first word held stable, exactly 8 reads issued, fifo_rd low afterward; raising word_ready -> words 2 and 3 follow, words_sent=3.
REQ-033 Bytes 0xAA,0xBB,0xCC, then flush -> word_out=0x00CCBBAA, word_bytes=3; the next flush with lane=0 -> no word.
REQ-034 fifo_empty held at 1 for 20 cycles -> fifo_rd never asserted, word_valid=0.
REQ-035 Two bytes collected, clear_n=0 for 1 cycle, then bytes 0x11..0x14 -> single word 0x14131211, words_sent=1.
REQ-036 fifo_data_valid pulsed with no preceding fifo_rd -> err=1 and sticky, lane unchanged.
